// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - MIPS32 integer-subset encodings, ALU/memory enums and boot PC
package mips_pkg;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_LHU    = 6'h25;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SH     = 6'h29;
  localparam logic [5:0] OP_SW     = 6'h2B;

  // R-type function codes
  localparam logic [5:0] F_SLL     = 6'h00;
  localparam logic [5:0] F_SRL     = 6'h02;
  localparam logic [5:0] F_SRA     = 6'h03;
  localparam logic [5:0] F_SLLV    = 6'h04;
  localparam logic [5:0] F_SRLV    = 6'h06;
  localparam logic [5:0] F_SRAV    = 6'h07;
  localparam logic [5:0] F_JR      = 6'h08;
  localparam logic [5:0] F_JALR    = 6'h09;
  localparam logic [5:0] F_SYSCALL = 6'h0C;
  localparam logic [5:0] F_ADD     = 6'h20;
  localparam logic [5:0] F_ADDU    = 6'h21;
  localparam logic [5:0] F_SUB     = 6'h22;
  localparam logic [5:0] F_SUBU    = 6'h23;
  localparam logic [5:0] F_AND     = 6'h24;
  localparam logic [5:0] F_OR      = 6'h25;
  localparam logic [5:0] F_XOR     = 6'h26;
  localparam logic [5:0] F_NOR     = 6'h27;
  localparam logic [5:0] F_SLT     = 6'h2A;
  localparam logic [5:0] F_SLTU    = 6'h2B;

  // REGIMM rt selectors
  localparam logic [4:0] RT_BLTZ = 5'h00;
  localparam logic [4:0] RT_BGEZ = 5'h01;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_e;

  typedef enum logic [1:0] {
    MEM_B, MEM_H, MEM_W
  } mem_size_e;

endpackage

// File: rtl/regfile.sv
// rtl/regfile.sv - 32x32 GPR file, two async read ports, one sync write port, $0 hardwired to zero
module regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i
);

  logic [31:0] reg_file [0:31];

  // Clear every register on reset; writes aimed at $0 are dropped so it always reads zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) reg_file[i] <= '0;
    end else if (we_i && (wa_i != 5'd0)) begin
      reg_file[wa_i] <= wd_i;
    end
  end

  assign rd1_o = reg_file[ra1_i];
  assign rd2_o = reg_file[ra2_i];

endmodule

// File: rtl/mips_single_cycle_top.sv
// rtl/mips_single_cycle_top.sv - single-cycle MIPS32 integer core with inline decoder, ALU, next-PC and memories
module mips_single_cycle_top
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = mips_pkg::RESET_PC,
  parameter int          IMEM_WORDS = 4096,
  parameter int          DMEM_WORDS = 4096
) (
  input logic clk,
  input logic reset
);

  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] dmem [DMEM_WORDS];

  logic [31:0] pc_q, pc_d, pc_plus4;
  logic [31:0] curr_pc_top, instr_top, wr_data_rf_top;
  logic [4:0]  rs_top, rt_top, rd_top, shamt, wa;
  logic [5:0]  opcode, funct;
  logic [15:0] imm16;
  logic [31:0] imm_sext, imm_zext, rs_data, rt_data;
  logic        is_r_type_top, is_i_type_top, reg_wr_top, use_link_reg_top;
  logic        wr_en, use_imm, imm_zero, shift_var, link, mem_rd, mem_wr;
  logic        ld_unsigned, br_taken, do_j, do_jr;
  alu_op_e     alu_op;
  mem_size_e   mem_size;
  logic [31:0] alu_b, alu_y, mem_word, load_data, st_data, st_word;
  logic [4:0]  shamt_eff;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [3:0]  st_be;

  assign curr_pc_top   = pc_q;
  assign pc_plus4      = pc_q + 32'd4;
  assign instr_top     = imem[curr_pc_top[13:2]];
  assign opcode        = instr_top[31:26];
  assign rs_top        = instr_top[25:21];
  assign rt_top        = instr_top[20:16];
  assign rd_top        = instr_top[15:11];
  assign shamt         = instr_top[10:6];
  assign funct         = instr_top[5:0];
  assign imm16         = instr_top[15:0];
  assign imm_sext      = {{16{imm16[15]}}, imm16};
  assign imm_zext      = {16'h0000, imm16};
  assign is_r_type_top = (opcode == OP_RTYPE);
  assign is_i_type_top = !is_r_type_top;

  regfile R1 (
    .clk   (clk),
    .rst_n (reset),
    .ra1_i (rs_top),
    .ra2_i (rt_top),
    .rd1_o (rs_data),
    .rd2_o (rt_data),
    .we_i  (reg_wr_top),
    .wa_i  (wa),
    .wd_i  (wr_data_rf_top)
  );

  // Decode opcode/funct into datapath controls; anything unrecognised falls through as a NOP
  always_comb begin
    alu_op = ALU_ADD;  use_imm = 1'b0;  imm_zero = 1'b0;  shift_var = 1'b0;
    wr_en = 1'b0;      wa = rd_top;     link = 1'b0;      use_link_reg_top = 1'b0;
    mem_rd = 1'b0;     mem_wr = 1'b0;   mem_size = MEM_W; ld_unsigned = 1'b0;
    br_taken = 1'b0;   do_j = 1'b0;     do_jr = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        wr_en = 1'b1;
        case (funct)
          F_ADD, F_ADDU: alu_op = ALU_ADD;
          F_SUB, F_SUBU: alu_op = ALU_SUB;
          F_AND:  alu_op = ALU_AND;
          F_OR:   alu_op = ALU_OR;
          F_XOR:  alu_op = ALU_XOR;
          F_NOR:  alu_op = ALU_NOR;
          F_SLT:  alu_op = ALU_SLT;
          F_SLTU: alu_op = ALU_SLTU;
          F_SLL:  alu_op = ALU_SLL;
          F_SRL:  alu_op = ALU_SRL;
          F_SRA:  alu_op = ALU_SRA;
          F_SLLV: begin alu_op = ALU_SLL; shift_var = 1'b1; end
          F_SRLV: begin alu_op = ALU_SRL; shift_var = 1'b1; end
          F_SRAV: begin alu_op = ALU_SRA; shift_var = 1'b1; end
          F_JR:   begin wr_en = 1'b0; do_jr = 1'b1; end
          F_JALR: begin do_jr = 1'b1; link = 1'b1; end
          F_SYSCALL: wr_en = 1'b0;
          default:   wr_en = 1'b0;
        endcase
      end
      OP_REGIMM: begin
        if (rt_top == RT_BLTZ) br_taken = rs_data[31];
        if (rt_top == RT_BGEZ) br_taken = !rs_data[31];
      end
      OP_J:    do_j = 1'b1;
      OP_JAL:  begin do_j = 1'b1; wr_en = 1'b1; wa = 5'd31; link = 1'b1; use_link_reg_top = 1'b1; end
      OP_BEQ:  br_taken = (rs_data == rt_data);
      OP_BNE:  br_taken = (rs_data != rt_data);
      OP_BLEZ: br_taken = rs_data[31] || (rs_data == 32'd0);
      OP_BGTZ: br_taken = !rs_data[31] && (rs_data != 32'd0);
      OP_ADDI, OP_ADDIU: begin wr_en = 1'b1; wa = rt_top; use_imm = 1'b1; end
      OP_SLTI:  begin wr_en = 1'b1; wa = rt_top; use_imm = 1'b1; alu_op = ALU_SLT;  end
      OP_SLTIU: begin wr_en = 1'b1; wa = rt_top; use_imm = 1'b1; alu_op = ALU_SLTU; end
      OP_ANDI:  begin wr_en = 1'b1; wa = rt_top; use_imm = 1'b1; imm_zero = 1'b1; alu_op = ALU_AND; end
      OP_ORI:   begin wr_en = 1'b1; wa = rt_top; use_imm = 1'b1; imm_zero = 1'b1; alu_op = ALU_OR;  end
      OP_XORI:  begin wr_en = 1'b1; wa = rt_top; use_imm = 1'b1; imm_zero = 1'b1; alu_op = ALU_XOR; end
      OP_LUI:   begin wr_en = 1'b1; wa = rt_top; alu_op = ALU_LUI; end
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: begin
        wr_en = 1'b1; wa = rt_top; use_imm = 1'b1; mem_rd = 1'b1;
        mem_size    = (opcode == OP_LW) ? MEM_W : ((opcode == OP_LH || opcode == OP_LHU) ? MEM_H : MEM_B);
        ld_unsigned = (opcode == OP_LBU) || (opcode == OP_LHU);
      end
      OP_SB, OP_SH, OP_SW: begin
        use_imm = 1'b1; mem_wr = 1'b1;
        mem_size = (opcode == OP_SW) ? MEM_W : ((opcode == OP_SH) ? MEM_H : MEM_B);
      end
      default: ;
    endcase
  end

  assign reg_wr_top = wr_en && (wa != 5'd0);

  // ALU: shifts act on rt, everything else on rs and the selected second operand
  always_comb begin
    alu_b     = use_imm ? (imm_zero ? imm_zext : imm_sext) : rt_data;
    shamt_eff = shift_var ? rs_data[4:0] : shamt;
    case (alu_op)
      ALU_ADD:  alu_y = rs_data + alu_b;
      ALU_SUB:  alu_y = rs_data - alu_b;
      ALU_AND:  alu_y = rs_data & alu_b;
      ALU_OR:   alu_y = rs_data | alu_b;
      ALU_XOR:  alu_y = rs_data ^ alu_b;
      ALU_NOR:  alu_y = ~(rs_data | alu_b);
      ALU_SLT:  alu_y = {31'd0, $signed(rs_data) < $signed(alu_b)};
      ALU_SLTU: alu_y = {31'd0, rs_data < alu_b};
      ALU_SLL:  alu_y = rt_data << shamt_eff;
      ALU_SRL:  alu_y = rt_data >> shamt_eff;
      ALU_SRA:  alu_y = $unsigned($signed(rt_data) >>> shamt_eff);
      ALU_LUI:  alu_y = {imm16, 16'h0000};
      default:  alu_y = 32'd0;
    endcase
  end

  // Load lane select (big-endian: byte 0 is bits 31:24) and store byte-enable merge
  always_comb begin
    mem_word = dmem[alu_y[13:2]];
    case (alu_y[1:0])
      2'd0:    ld_byte = mem_word[31:24];
      2'd1:    ld_byte = mem_word[23:16];
      2'd2:    ld_byte = mem_word[15:8];
      default: ld_byte = mem_word[7:0];
    endcase
    ld_half = alu_y[1] ? mem_word[15:0] : mem_word[31:16];
    case (mem_size)
      MEM_B: begin
        load_data = ld_unsigned ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
        st_be     = 4'b1000 >> alu_y[1:0];
        st_data   = {4{rt_data[7:0]}};
      end
      MEM_H: begin
        load_data = ld_unsigned ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
        st_be     = alu_y[1] ? 4'b0011 : 4'b1100;
        st_data   = {2{rt_data[15:0]}};
      end
      default: begin
        load_data = mem_word;
        st_be     = 4'b1111;
        st_data   = rt_data;
      end
    endcase
    for (int b = 0; b < 4; b++) st_word[8*b +: 8] = st_be[b] ? st_data[8*b +: 8] : mem_word[8*b +: 8];
  end

  assign wr_data_rf_top = link ? pc_plus4 : (mem_rd ? load_data : alu_y);

  // Next PC: taken branch beats jump, jump beats register jump, else fall through
  always_comb begin
    pc_d = pc_plus4;
    if (br_taken)   pc_d = pc_plus4 + {imm_sext[29:0], 2'b00};
    else if (do_j)  pc_d = {pc_plus4[31:28], instr_top[25:0], 2'b00};
    else if (do_jr) pc_d = rs_data;
  end

  // Program counter, reloaded with the boot address on reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  // Data memory store port; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_wr) dmem[alu_y[13:2]] <= st_word;
  end

endmodule

// File: tb/tb_mips_single_cycle_top.sv
// tb/tb_mips_single_cycle_top.sv - lockstep bench for mips_single_cycle_top against an instruction-level model
module tb_mips_single_cycle_top;

  localparam logic [31:0] BASE = 32'hBFC0_0000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] m_pc;
  logic [31:0] m_regs [32];
  logic [31:0] m_imem [4096];
  logic [31:0] m_dmem [4096];

  always #5 clk = ~clk;

  mips_single_cycle_top dut (.clk(clk), .reset(reset));

  function automatic logic [31:0] r_ins(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [4:0] sa, logic [5:0] fn);
    return {6'h00, rs, rt, rd, sa, fn};
  endfunction

  function automatic logic [31:0] i_ins(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_ins(logic [5:0] op, logic [25:0] t);
    return {op, t};
  endfunction

  // Instruction-set model: executes the instruction at m_pc and reports its register write
  function automatic void mdl_step(output logic wr, output logic [4:0] wa, output logic [31:0] wd);
    logic [31:0] ins, rsv, rtv, simm, zimm, npc, addr, w, t;
    logic [5:0]  op, fn;
    logic [4:0]  rt, sa;
    int          lane, sh;
    ins  = m_imem[m_pc[13:2]];
    op   = ins[31:26]; fn = ins[5:0]; rt = ins[20:16]; sa = ins[10:6];
    rsv  = m_regs[ins[25:21]]; rtv = m_regs[rt];
    simm = {{16{ins[15]}}, ins[15:0]}; zimm = {16'h0, ins[15:0]};
    npc  = m_pc + 4; wr = 1'b0; wa = rt; wd = 32'd0;
    addr = rsv + simm; w = m_dmem[addr[13:2]]; lane = int'(addr[1:0]);
    case (op)
      6'h00: begin
        wa = ins[15:11]; wr = 1'b1;
        case (fn)
          6'h20, 6'h21: wd = rsv + rtv;
          6'h22, 6'h23: wd = rsv - rtv;
          6'h24: wd = rsv & rtv;
          6'h25: wd = rsv | rtv;
          6'h26: wd = rsv ^ rtv;
          6'h27: wd = ~(rsv | rtv);
          6'h2A: wd = ($signed(rsv) < $signed(rtv)) ? 32'd1 : 32'd0;
          6'h2B: wd = (rsv < rtv) ? 32'd1 : 32'd0;
          6'h00: wd = rtv << sa;
          6'h02: wd = rtv >> sa;
          6'h03: wd = $unsigned($signed(rtv) >>> sa);
          6'h04: wd = rtv << rsv[4:0];
          6'h06: wd = rtv >> rsv[4:0];
          6'h07: wd = $unsigned($signed(rtv) >>> rsv[4:0]);
          6'h08: begin wr = 1'b0; npc = rsv; end
          6'h09: begin wd = m_pc + 4; npc = rsv; end
          default: wr = 1'b0;
        endcase
      end
      6'h01: begin
        if (rt == 5'd0 && $signed(rsv) < 0)  npc = m_pc + 4 + (simm << 2);
        if (rt == 5'd1 && $signed(rsv) >= 0) npc = m_pc + 4 + (simm << 2);
      end
      6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
      6'h03: begin wr = 1'b1; wa = 5'd31; wd = m_pc + 4; npc = {npc[31:28], ins[25:0], 2'b00}; end
      6'h04: if (rsv == rtv) npc = m_pc + 4 + (simm << 2);
      6'h05: if (rsv != rtv) npc = m_pc + 4 + (simm << 2);
      6'h06: if ($signed(rsv) <= 0) npc = m_pc + 4 + (simm << 2);
      6'h07: if ($signed(rsv) > 0) npc = m_pc + 4 + (simm << 2);
      6'h08, 6'h09: begin wr = 1'b1; wd = rsv + simm; end
      6'h0A: begin wr = 1'b1; wd = ($signed(rsv) < $signed(simm)) ? 32'd1 : 32'd0; end
      6'h0B: begin wr = 1'b1; wd = (rsv < simm) ? 32'd1 : 32'd0; end
      6'h0C: begin wr = 1'b1; wd = rsv & zimm; end
      6'h0D: begin wr = 1'b1; wd = rsv | zimm; end
      6'h0E: begin wr = 1'b1; wd = rsv ^ zimm; end
      6'h0F: begin wr = 1'b1; wd = zimm << 16; end
      6'h20, 6'h24: begin
        t = (w >> (8 * (3 - lane))) & 32'hFF; wr = 1'b1;
        wd = (op == 6'h20 && t[7]) ? (t | 32'hFFFF_FF00) : t;
      end
      6'h21, 6'h25: begin
        t = (w >> (16 * (1 - lane / 2))) & 32'hFFFF; wr = 1'b1;
        wd = (op == 6'h21 && t[15]) ? (t | 32'hFFFF_0000) : t;
      end
      6'h23: begin wr = 1'b1; wd = w; end
      6'h28: begin sh = 8 * (3 - lane);       m_dmem[addr[13:2]] = (w & ~(32'hFF << sh))   | ((rtv & 32'hFF) << sh);   end
      6'h29: begin sh = 16 * (1 - lane / 2);  m_dmem[addr[13:2]] = (w & ~(32'hFFFF << sh)) | ((rtv & 32'hFFFF) << sh); end
      6'h2B: m_dmem[addr[13:2]] = rtv;
      default: ;
    endcase
    if (wa == 5'd0) wr = 1'b0;
    if (wr) m_regs[wa] = wd;
    m_pc = npc;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) begin m_imem[i] = 32'd0; m_dmem[i] = 32'd0; end
  endtask

  task automatic load_prog();
    for (int i = 0; i < 4096; i++) begin dut.imem[i] = m_imem[i]; dut.dmem[i] = m_dmem[i]; end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #12;
    @(negedge clk);
    reset = 1'b1;
    #1;
    m_pc = BASE;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    logic [31:0] tgt;
    clear_mem();
    tgt = (BASE + 32'd80) >> 2;
    m_imem[0]  = i_ins(6'h0F, 5'd0, 5'd8, 16'h1234);
    m_imem[1]  = i_ins(6'h0D, 5'd8, 5'd8, 16'h5678);
    m_imem[2]  = i_ins(6'h28, 5'd0, 5'd8, 16'd3);
    m_imem[3]  = i_ins(6'h20, 5'd0, 5'd9, 16'd3);
    m_imem[4]  = i_ins(6'h09, 5'd0, 5'd10, 16'h0080);
    m_imem[5]  = i_ins(6'h28, 5'd0, 5'd10, 16'd1);
    m_imem[6]  = i_ins(6'h20, 5'd0, 5'd11, 16'd1);
    m_imem[7]  = i_ins(6'h24, 5'd0, 5'd12, 16'd1);
    m_imem[8]  = i_ins(6'h04, 5'd0, 5'd0, 16'd2);
    m_imem[9]  = i_ins(6'h09, 5'd0, 5'd13, 16'd1);
    m_imem[10] = i_ins(6'h09, 5'd0, 5'd13, 16'd2);
    m_imem[11] = i_ins(6'h05, 5'd0, 5'd0, 16'd5);
    m_imem[12] = j_ins(6'h03, tgt[25:0]);
    m_imem[13] = i_ins(6'h09, 5'd0, 5'd1, 16'd5);
    m_imem[14] = r_ins(5'd1, 5'd1, 5'd0, 5'd0, 6'h21);
    m_imem[15] = i_ins(6'h0F, 5'd0, 5'd3, 16'h8000);
    m_imem[16] = r_ins(5'd0, 5'd3, 5'd4, 5'd4, 6'h03);
    m_imem[17] = i_ins(6'h09, 5'd0, 5'd2, 16'd10);
    m_imem[18] = 32'h0000_000C;
    m_imem[20] = r_ins(5'd31, 5'd0, 5'd0, 5'd0, 6'h08);
    load_prog();
    do_reset();
    checks++; if (dut.curr_pc_top !== BASE) begin errors++; $display("FAIL dir_reset_pc got %h exp %h", dut.curr_pc_top, BASE); end
    tick(); tick();
    checks++; if (dut.R1.reg_file[8] !== 32'h1234_5678) begin errors++; $display("FAIL dir_lui_ori got %h exp 12345678", dut.R1.reg_file[8]); end
    tick(); tick();
    checks++; if (dut.R1.reg_file[9] !== 32'h0000_0078) begin errors++; $display("FAIL dir_lb_pos got %h exp 00000078", dut.R1.reg_file[9]); end
    tick(); tick(); tick();
    checks++; if (dut.R1.reg_file[11] !== 32'hFFFF_FF80) begin errors++; $display("FAIL dir_lb_neg got %h exp ffffff80", dut.R1.reg_file[11]); end
    tick();
    checks++; if (dut.R1.reg_file[12] !== 32'h0000_0080) begin errors++; $display("FAIL dir_lbu got %h exp 00000080", dut.R1.reg_file[12]); end
    checks++; if (dut.curr_pc_top !== BASE + 32'd32) begin errors++; $display("FAIL dir_pc_at_beq got %h exp %h", dut.curr_pc_top, BASE + 32'd32); end
    tick();
    checks++; if (dut.curr_pc_top !== BASE + 32'd44) begin errors++; $display("FAIL dir_beq_taken got %h exp %h", dut.curr_pc_top, BASE + 32'd44); end
    tick();
    checks++; if (dut.curr_pc_top !== BASE + 32'd48) begin errors++; $display("FAIL dir_bne_not_taken got %h exp %h", dut.curr_pc_top, BASE + 32'd48); end
    checks++; if (dut.use_link_reg_top !== 1'b1 || dut.is_i_type_top !== 1'b1 || dut.is_r_type_top !== 1'b0)
      begin errors++; $display("FAIL dir_jal_class got link=%b i=%b r=%b exp 1 1 0", dut.use_link_reg_top, dut.is_i_type_top, dut.is_r_type_top); end
    checks++; if (dut.reg_wr_top !== 1'b1 || dut.wr_data_rf_top !== BASE + 32'd52)
      begin errors++; $display("FAIL dir_jal_wr got wr=%b data=%h exp 1 %h", dut.reg_wr_top, dut.wr_data_rf_top, BASE + 32'd52); end
    tick();
    checks++; if (dut.curr_pc_top !== BASE + 32'd80) begin errors++; $display("FAIL dir_jal_target got %h exp %h", dut.curr_pc_top, BASE + 32'd80); end
    checks++; if (dut.R1.reg_file[31] !== BASE + 32'd52) begin errors++; $display("FAIL dir_jal_link got %h exp %h", dut.R1.reg_file[31], BASE + 32'd52); end
    tick();
    checks++; if (dut.curr_pc_top !== BASE + 32'd52) begin errors++; $display("FAIL dir_jr_return got %h exp %h", dut.curr_pc_top, BASE + 32'd52); end
    tick();
    checks++; if (dut.reg_wr_top !== 1'b0) begin errors++; $display("FAIL dir_r0_wr got %b exp 0", dut.reg_wr_top); end
    tick();
    checks++; if (dut.R1.reg_file[0] !== 32'd0 || dut.R1.reg_file[1] !== 32'd5)
      begin errors++; $display("FAIL dir_r0_discard got r0=%h r1=%h exp 0 5", dut.R1.reg_file[0], dut.R1.reg_file[1]); end
    tick(); tick();
    checks++; if (dut.R1.reg_file[4] !== 32'hF800_0000) begin errors++; $display("FAIL dir_sra got %h exp f8000000", dut.R1.reg_file[4]); end
    for (int k = 0; k < 10 && !(dut.instr_top === 32'h0000_000C && dut.R1.reg_file[2] === 32'd10); k++) tick();
    checks++; if (dut.instr_top !== 32'h0000_000C || dut.R1.reg_file[2] !== 32'd10)
      begin errors++; $display("FAIL dir_exit got instr=%h v0=%h exp 0000000c 0000000a", dut.instr_top, dut.R1.reg_file[2]); end
    checks++; if (dut.is_r_type_top !== 1'b1 || dut.reg_wr_top !== 1'b0)
      begin errors++; $display("FAIL dir_syscall got r=%b wr=%b exp 1 0", dut.is_r_type_top, dut.reg_wr_top); end
  endtask

  task automatic test_reset();
    int bad;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++; if (dut.curr_pc_top !== BASE) begin errors++; $display("FAIL rst_async_pc got %h exp %h", dut.curr_pc_top, BASE); end
    bad = 0;
    for (int i = 0; i < 32; i++) if (dut.R1.reg_file[i] !== 32'd0) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL rst_regs got %0d nonzero exp 0", bad); end
    checks++; if (dut.instr_top !== m_imem[0]) begin errors++; $display("FAIL rst_fetch got %h exp %h", dut.instr_top, m_imem[0]); end
    @(negedge clk);
    reset = 1'b1;
    tick();
    checks++; if (dut.curr_pc_top !== BASE + 32'd4) begin errors++; $display("FAIL rst_first_commit got %h exp %h", dut.curr_pc_top, BASE + 32'd4); end
  endtask

  task automatic test_branches();
    logic [31:0] exp_pc;
    int          vals [3];
    int          v;
    bit          taken;
    vals[0] = 0; vals[1] = -1; vals[2] = 1;
    for (int op = 6; op <= 7; op++) begin
      for (int k = 0; k < 3; k++) begin
        v = vals[k];
        clear_mem();
        m_imem[0] = i_ins(6'h09, 5'd0, 5'd5, 16'(v));
        m_imem[1] = i_ins(6'(op), 5'd5, 5'd0, 16'd3);
        load_prog();
        do_reset();
        tick(); tick();
        taken  = (op == 6) ? (v <= 0) : (v > 0);
        exp_pc = taken ? BASE + 32'd20 : BASE + 32'd8;
        checks++; if (dut.curr_pc_top !== exp_pc)
          begin errors++; $display("FAIL br_op%0d_val%0d got %h exp %h", op, v, dut.curr_pc_top, exp_pc); end
      end
    end
  endtask

  task automatic test_random();
    logic [5:0]  ops [24];
    logic [5:0]  fns [16];
    logic [31:0] exp_pc, ewd;
    logic [4:0]  ewa;
    logic        ew;
    int          sel, printed;
    ops = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C,
            6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h09};
    fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
            6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h07, 6'h09};
    clear_mem();
    for (int i = 0; i < 4096; i++) begin
      m_dmem[i] = $urandom;
      sel = $urandom_range(0, 99);
      if (sel < 5)
        m_imem[i] = $urandom;
      else if (sel < 40)
        m_imem[i] = r_ins(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                          5'($urandom), (sel < 38) ? fns[$urandom_range(0, 15)] : 6'h06);
      else
        m_imem[i] = i_ins(ops[$urandom_range(0, 23)], 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)), 16'($urandom));
    end
    load_prog();
    do_reset();
    for (int s = 0; s < 3000; s++) begin
      exp_pc = m_pc;
      mdl_step(ew, ewa, ewd);
      checks++; if (dut.curr_pc_top !== exp_pc) begin errors++; $display("FAIL rnd_pc step %0d got %h exp %h", s, dut.curr_pc_top, exp_pc); break; end
      checks++; if (dut.reg_wr_top !== ew) begin errors++; $display("FAIL rnd_reg_wr step %0d instr %h got %b exp %b", s, dut.instr_top, dut.reg_wr_top, ew); break; end
      if (ew) begin
        checks++; if (dut.wr_data_rf_top !== ewd) begin errors++; $display("FAIL rnd_wr_data step %0d instr %h got %h exp %h", s, dut.instr_top, dut.wr_data_rf_top, ewd); break; end
      end
      tick();
      if (ew) begin
        checks++; if (dut.R1.reg_file[ewa] !== ewd) begin errors++; $display("FAIL rnd_commit step %0d reg %0d got %h exp %h", s, ewa, dut.R1.reg_file[ewa], ewd); break; end
      end
    end
    printed = 0;
    for (int i = 0; i < 32; i++) begin
      checks++; if (dut.R1.reg_file[i] !== m_regs[i]) begin errors++; $display("FAIL rnd_final_reg %0d got %h exp %h", i, dut.R1.reg_file[i], m_regs[i]); end
    end
    for (int i = 0; i < 4096; i++) begin
      checks++;
      if (dut.dmem[i] !== m_dmem[i]) begin
        errors++;
        if (printed < 8) $display("FAIL rnd_final_dmem word %0d got %h exp %h", i, dut.dmem[i], m_dmem[i]);
        printed++;
      end
    end
  endtask

  initial begin
    test_directed();
    test_reset();
    test_branches();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
